// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32 pipeline types: opcode constants, ALU/operand/immediate enums, ID/EX control bundle.
// The CSR fields of ctrl_bundle_t exist only when PL_RV32_CTRL_CSR_EN is defined.
package rv32_pipeline_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } ALU_OPCODE;

  typedef enum logic {REGISTER_A, PC} ALU_OPERAND_A_SRC;
  typedef enum logic {REGISTER_B, IMMEDIATE} ALU_OPERAND_B_SRC;
  typedef enum logic [2:0] {I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} IMMEDIATE_SELECT;

  typedef struct packed {
    ALU_OPCODE        alu_op;
    ALU_OPERAND_A_SRC src_a;
    ALU_OPERAND_B_SRC src_b;
    IMMEDIATE_SELECT  imm_sel;
    logic             reg_write_en;
    logic             mem_read_en;
    logic             mem_write_en;
    logic             write_back_sel;
    logic             branch;
    logic             jump;
    logic [2:0]       funct3;
    logic             illegal;
`ifdef PL_RV32_CTRL_CSR_EN
    logic [11:0]      csr_addr;
    logic             csr_write_en;
`endif
  } ctrl_bundle_t;

  // SUB only exists in the register form; SRA/SRAI are both selected by bit 30.
  function automatic ALU_OPCODE alu_from_funct(logic [2:0] f3, logic alt, logic is_imm);
    case (f3)
      3'b000:  return (alt && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pl_rv32_load_scoreboard.sv
// Load-use scoreboard: rd of loads accepted by EX, kept for LOAD_LATENCY cycles,
// plus the source-register compare against those and against a load still held in ID/EX.
module pl_rv32_load_scoreboard
  import rv32_pipeline_pkg::*;
#(
  parameter int LOAD_LATENCY = 2,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic                  held_load,
  input  logic [REG_ADDR_W-1:0] held_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  output logic                  hazard
);

  logic [LOAD_LATENCY-1:0]                 sb_vld;
  logic [LOAD_LATENCY-1:0][REG_ADDR_W-1:0] sb_rd;
  logic                                    hit1, hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_vld <= '0;
      sb_rd  <= '0;
    end else begin
      sb_vld[0] <= push;
      sb_rd[0]  <= push_rd;
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
    end
  end

  always_comb begin
    hit1 = held_load && (held_rd == rs1);
    hit2 = held_load && (held_rd == rs2);
    for (int i = 0; i < LOAD_LATENCY; i++) begin
      if (sb_vld[i] && sb_rd[i] == rs1) hit1 = 1'b1;
      if (sb_vld[i] && sb_rd[i] == rs2) hit2 = 1'b1;
    end
    // x0 is hardwired, so it never waits on a load.
    hazard = (use_rs1 && rs1 != '0 && hit1) || (use_rs2 && rs2 != '0 && hit2);
  end

endmodule

// File: rtl/pl_rv32_decode_ctrl.sv
// RV32I decode/control stage with ID/EX register, valid/ready handshake, flush and load-use stall.
// Define PL_RV32_CTRL_CSR_EN to decode SYSTEM CSR instructions; otherwise SYSTEM is illegal.
module pl_rv32_decode_ctrl
  import rv32_pipeline_pkg::*;
#(
  parameter int LOAD_LATENCY = 2,
  parameter int REG_ADDR_W   = 5,
  parameter int XLEN         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [31:0]           id_instr,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output ALU_OPCODE             ex_alu_op,
  output ALU_OPERAND_A_SRC      ex_alu_src_a_sel,
  output ALU_OPERAND_B_SRC      ex_alu_src_b_sel,
  output IMMEDIATE_SELECT       ex_imm_sel,
  output logic                  ex_reg_write_en,
  output logic                  ex_mem_read_en,
  output logic                  ex_mem_write_en,
  output logic                  ex_write_back_sel,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [2:0]            ex_funct3,
  output logic                  ex_illegal
`ifdef PL_RV32_CTRL_CSR_EN
  ,
  input  logic                  csr_illegal_access,
  output logic [11:0]           ex_csr_addr,
  output logic                  ex_csr_write_en
`endif
);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 4 || XLEN != 32) begin : g_bad_param
    $error("pl_rv32_decode_ctrl: LOAD_LATENCY must be 1..4 and XLEN must be 32");
  end

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  ctrl_bundle_t          d, bundle_q;
  logic                  legal, use_rs1, use_rs2, hazard, capture;

  assign rs1    = REG_ADDR_W'(id_instr[19:15]);
  assign rs2    = REG_ADDR_W'(id_instr[24:20]);
  assign rd     = REG_ADDR_W'(id_instr[11:7]);
  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];
  assign funct7 = id_instr[31:25];

  always_comb begin
    d        = '0;
    d.funct3 = funct3;
    legal    = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        d.src_b = IMMEDIATE; d.mem_read_en = 1'b1; d.write_back_sel = 1'b1;
        d.reg_write_en = 1'b1; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        d.imm_sel = S_TYPE; d.src_b = IMMEDIATE; d.mem_write_en = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        d.alu_op = alu_from_funct(funct3, id_instr[30], 1'b1);
        d.src_b = IMMEDIATE; d.reg_write_en = 1'b1; use_rs1 = 1'b1;
      end
      OPC_OP: begin
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        d.alu_op = alu_from_funct(funct3, id_instr[30], 1'b0);
        d.reg_write_en = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        d.imm_sel = B_TYPE; d.alu_op = ALU_SUB; d.branch = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        d.imm_sel = J_TYPE; d.src_a = PC; d.src_b = IMMEDIATE;
        d.jump = 1'b1; d.reg_write_en = 1'b1;
      end
      OPC_JALR: begin
        d.src_b = IMMEDIATE; d.jump = 1'b1; d.reg_write_en = 1'b1; use_rs1 = 1'b1;
      end
      OPC_LUI: begin
        d.imm_sel = U_TYPE; d.alu_op = ALU_PASS_B; d.src_b = IMMEDIATE; d.reg_write_en = 1'b1;
      end
      OPC_AUIPC: begin
        d.imm_sel = U_TYPE; d.src_a = PC; d.src_b = IMMEDIATE; d.reg_write_en = 1'b1;
      end
`ifdef PL_RV32_CTRL_CSR_EN
      OPC_SYSTEM: begin
        // funct3 000/100 are ECALL/EBREAK/reserved, not CSR accesses.
        legal          = (funct3 != 3'b000) && (funct3 != 3'b100);
        d.reg_write_en = 1'b1;
        d.csr_addr     = id_instr[31:20];
        d.csr_write_en = (funct3[1:0] == 2'b01) || (id_instr[19:15] != 5'd0);
        use_rs1        = !funct3[2];
      end
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d         = '0;
      d.funct3  = funct3;
      d.illegal = 1'b1;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
    end
`ifdef PL_RV32_CTRL_CSR_EN
    if (csr_illegal_access) begin
      d.illegal      = 1'b1;
      d.reg_write_en = 1'b0;
      d.mem_read_en  = 1'b0;
      d.mem_write_en = 1'b0;
      d.branch       = 1'b0;
      d.jump         = 1'b0;
      d.csr_write_en = 1'b0;
    end
`endif
  end

  pl_rv32_load_scoreboard #(
    .LOAD_LATENCY(LOAD_LATENCY),
    .REG_ADDR_W  (REG_ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .push     (ex_valid && ex_ready && bundle_q.mem_read_en && ex_rd != '0),
    .push_rd  (ex_rd),
    .held_load(ex_valid && bundle_q.mem_read_en && ex_rd != '0),
    .held_rd  (ex_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .use_rs1  (use_rs1),
    .use_rs2  (use_rs2),
    .hazard   (hazard)
  );

  assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign capture  = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      bundle_q <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (capture) begin
      ex_valid <= 1'b1;
      bundle_q <= d;
      ex_rs1   <= rs1;
      ex_rs2   <= rs2;
      ex_rd    <= rd;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_alu_op         = bundle_q.alu_op;
  assign ex_alu_src_a_sel  = bundle_q.src_a;
  assign ex_alu_src_b_sel  = bundle_q.src_b;
  assign ex_imm_sel        = bundle_q.imm_sel;
  assign ex_reg_write_en   = bundle_q.reg_write_en;
  assign ex_mem_read_en    = bundle_q.mem_read_en;
  assign ex_mem_write_en   = bundle_q.mem_write_en;
  assign ex_write_back_sel = bundle_q.write_back_sel;
  assign ex_branch         = bundle_q.branch;
  assign ex_jump           = bundle_q.jump;
  assign ex_funct3         = bundle_q.funct3;
  assign ex_illegal        = bundle_q.illegal;
`ifdef PL_RV32_CTRL_CSR_EN
  assign ex_csr_addr       = bundle_q.csr_addr;
  assign ex_csr_write_en   = bundle_q.csr_write_en;
`endif

endmodule

// File: tb/tb_pl_rv32_decode_ctrl.sv
// Bench for pl_rv32_decode_ctrl: directed scenarios, then random traffic against a reference model
// that tracks accepted loads by acceptance time.
module tb_pl_rv32_decode_ctrl;
  import rv32_pipeline_pkg::*;

  localparam int LL = 2;

  logic             clk = 1'b0;
  logic             rst, id_valid, id_ready, flush, ex_valid, ex_ready;
  logic [31:0]      id_instr;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  ALU_OPCODE        ex_alu_op;
  ALU_OPERAND_A_SRC ex_alu_src_a_sel;
  ALU_OPERAND_B_SRC ex_alu_src_b_sel;
  IMMEDIATE_SELECT  ex_imm_sel;
  logic             ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_write_back_sel;
  logic             ex_branch, ex_jump, ex_illegal;
  logic [2:0]       ex_funct3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pl_rv32_decode_ctrl #(.LOAD_LATENCY(LL), .REG_ADDR_W(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src_a_sel(ex_alu_src_a_sel), .ex_alu_src_b_sel(ex_alu_src_b_sel),
    .ex_imm_sel(ex_imm_sel), .ex_reg_write_en(ex_reg_write_en),
    .ex_mem_read_en(ex_mem_read_en), .ex_mem_write_en(ex_mem_write_en),
    .ex_write_back_sel(ex_write_back_sel), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic [3:0] alu;
    logic       a, b;
    logic [2:0] imm;
    logic       rw, mr, mw, wb, br, jmp;
    logic [2:0] f3;
    logic       ill, u1, u2;
  } ref_t;

  typedef struct { logic [4:0] rd; int k; } ld_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] arith(logic [2:0] f3, logic alt, logic is_imm);
    ALU_OPCODE tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (f3 == 3'd0 && alt && !is_imm) return ALU_SUB;
    if (f3 == 3'd5 && alt) return ALU_SRA;
    return tbl[f3];
  endfunction

  function automatic ref_t ref_decode(logic [31:0] w);
    ref_t r;
    bit   ok;
    r = '{default: '0};
    ok = 1;
    case (w[6:0])
      7'b0000011: begin r.b = 1; r.mr = 1; r.wb = 1; r.rw = 1; r.u1 = 1; end
      7'b0100011: begin r.imm = S_TYPE; r.b = 1; r.mw = 1; r.u1 = 1; r.u2 = 1; end
      7'b0010011: begin r.alu = arith(w[14:12], w[30], 1'b1); r.b = 1; r.rw = 1; r.u1 = 1; end
      7'b0110011: begin
        ok = (w[31:25] == 7'h00) || (w[31:25] == 7'h20 && (w[14:12] == 3'd0 || w[14:12] == 3'd5));
        r.alu = arith(w[14:12], w[30], 1'b0); r.rw = 1; r.u1 = 1; r.u2 = 1;
      end
      7'b1100011: begin r.imm = B_TYPE; r.alu = ALU_SUB; r.br = 1; r.u1 = 1; r.u2 = 1; end
      7'b1101111: begin r.imm = J_TYPE; r.a = 1; r.b = 1; r.jmp = 1; r.rw = 1; end
      7'b1100111: begin r.b = 1; r.jmp = 1; r.rw = 1; r.u1 = 1; end
      7'b0110111: begin r.imm = U_TYPE; r.alu = ALU_PASS_B; r.b = 1; r.rw = 1; end
      7'b0010111: begin r.imm = U_TYPE; r.a = 1; r.b = 1; r.rw = 1; end
      default:    ok = 0;
    endcase
    if (!ok) begin
      r = '{default: '0};
      r.ill = 1;
    end
    r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7]; r.f3 = w[14:12];
    return r;
  endfunction

  function automatic logic [33:0] pack_ref(ref_t r);
    return {r.rs1, r.rs2, r.rd, r.alu, r.a, r.b, r.imm, r.rw, r.mr, r.mw, r.wb, r.br, r.jmp, r.f3, r.ill};
  endfunction

  function automatic logic [33:0] got_bundle();
    return {ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src_a_sel, ex_alu_src_b_sel, ex_imm_sel,
            ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_write_back_sel, ex_branch,
            ex_jump, ex_funct3, ex_illegal};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [19:0] u20;
    rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom); imm = 12'($urandom); u20 = 20'($urandom);
    case ($urandom_range(0, 11))
      0:  return {imm, rs1, 3'b010, rd, 7'b0000011};
      1:  return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      2:  return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'b0010011};
      3:  return {((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                  rs2, rs1, f3, rd, 7'b0110011};
      4:  return {($urandom_range(0, 2) == 0) ? 7'h01 : 7'h20, rs2, rs1, f3, rd, 7'b0110011};
      5:  return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b1100011};
      6:  return {u20, rd, 7'b1101111};
      7:  return {imm, rs1, 3'b000, rd, 7'b1100111};
      8:  return {u20, rd, 7'b0110111};
      9:  return {u20, rd, 7'b0010111};
      10: return {imm, rs1, f3, rd, 7'b1110011};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1; id_valid = 0; id_instr = '0; flush = 0; ex_ready = 0;
    tick(); tick();
    rst = 0;
    #1;
    total++;
    if ({ex_valid, got_bundle()} !== 35'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {ex_valid, got_bundle()});
    end
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready got=%b exp=1", id_ready); end
  endtask

  task automatic test_addi();
    id_valid = 1; id_instr = 32'h00500093; ex_ready = 1;
    #1;
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%b exp=1", id_ready); end
    tick();
    id_valid = 0;
    total++;
    if (!(ex_valid === 1 && ex_rd === 5'd1 && ex_alu_op === ALU_ADD && ex_imm_sel === I_TYPE &&
          ex_reg_write_en === 1 && ex_alu_src_b_sel === IMMEDIATE && ex_illegal === 0)) begin
      bad++; $display("FAIL addi_bundle got=%h v=%b", got_bundle(), ex_valid);
    end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b exp=0", ex_valid); end
  endtask

  task automatic test_load_use();
    int stalls;
    bit got_in;
    stalls = 0; got_in = 0;
    id_valid = 1; id_instr = 32'h0000A103; ex_ready = 1;
    tick();
    total++;
    if (!(ex_valid === 1 && ex_mem_read_en === 1 && ex_write_back_sel === 1 && ex_rd === 5'd2)) begin
      bad++; $display("FAIL lw_bundle got=%h", got_bundle());
    end
    id_instr = 32'h002101B3;
    for (int i = 0; i < 10 && !got_in; i++) begin
      #1;
      if (id_ready) got_in = 1;
      else stalls++;
      tick();
    end
    id_valid = 0;
    total++;
    if (!got_in || stalls != 3) begin
      bad++; $display("FAIL load_use_stalls got=%0d accepted=%b exp=3", stalls, got_in);
    end
    total++;
    if (!(ex_valid === 1 && ex_rd === 5'd3 && ex_rs1 === 5'd2 && ex_rs2 === 5'd2 && ex_alu_op === ALU_ADD)) begin
      bad++; $display("FAIL load_use_add got=%h", got_bundle());
    end
    tick();
  endtask

  task automatic test_load_x0();
    id_valid = 1; id_instr = 32'h0000A003; ex_ready = 1;
    tick();
    id_instr = 32'h000001B3;
    #1;
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL load_x0_ready got=%b exp=1", id_ready); end
    tick();
    id_valid = 0;
    total++;
    if (!(ex_valid === 1 && ex_rd === 5'd3)) begin bad++; $display("FAIL load_x0_add got=%h", got_bundle()); end
    tick();
  endtask

  task automatic test_stall_store();
    logic [33:0] snap;
    id_valid = 1; id_instr = 32'h0020A223; ex_ready = 1;
    tick();
    snap = got_bundle();
    id_instr = 32'h00500093; ex_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (!(id_ready === 0 && ex_valid === 1 && ex_mem_write_en === 1 && ex_imm_sel === S_TYPE &&
            ex_rs1 === 5'd1 && ex_rs2 === 5'd2 && ex_funct3 === 3'd2 && got_bundle() === snap)) begin
        bad++; $display("FAIL store_stall cyc=%0d got=%h rdy=%b exp_bundle=%h", i, got_bundle(), id_ready, snap);
      end
      tick();
    end
    ex_ready = 1;
    #1;
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL store_release_ready got=%b exp=1", id_ready); end
    tick();
    id_valid = 0;
    total++;
    if (!(ex_valid === 1 && ex_rd === 5'd1 && ex_mem_write_en === 0 && ex_alu_src_b_sel === IMMEDIATE)) begin
      bad++; $display("FAIL store_release_next got=%h", got_bundle());
    end
    tick();
  endtask

  task automatic test_flush();
    id_valid = 1; id_instr = 32'h008000EF; ex_ready = 1;
    tick();
    total++;
    if (!(ex_jump === 1 && ex_alu_src_a_sel === PC && ex_imm_sel === J_TYPE && ex_reg_write_en === 1 && ex_rd === 5'd1)) begin
      bad++; $display("FAIL jal_bundle got=%h", got_bundle());
    end
    id_instr = 32'h00500093; flush = 1; ex_ready = 0;
    #1;
    total++;
    if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", id_ready); end
    tick();
    flush = 0; id_valid = 0; ex_ready = 1;
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ex_valid); end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_no_capture got=%b exp=0", ex_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] tbl [4] = '{32'h00000000, 32'h34011073, 32'h00500090, 32'h022081B3};
    ex_ready = 1;
    for (int i = 0; i < 4; i++) begin
      id_valid = 1; id_instr = tbl[i];
      tick();
      id_valid = 0;
      total++;
      if (!(ex_valid === 1 && ex_illegal === 1 &&
            {ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_branch, ex_jump} === 5'b0)) begin
        bad++; $display("FAIL illegal_%0d instr=%h got=%h v=%b", i, tbl[i], got_bundle(), ex_valid);
      end
    end
    tick();
  endtask

  task automatic test_midstall_reset();
    id_valid = 1; id_instr = 32'h0020A223; ex_ready = 1;
    tick();
    id_valid = 0; ex_ready = 0;
    tick();
    total++;
    if (ex_valid !== 1'b1) begin bad++; $display("FAIL midstall_hold got=%b exp=1", ex_valid); end
    rst = 1;
    tick();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL midstall_reset got=%b exp=0", ex_valid); end
    rst = 0;
  endtask

  task automatic test_random();
    ld_t  loads[$];
    ref_t m, cur;
    bit   m_valid, hz, exp_ready;
    int   cyc;
    rst = 1; id_valid = 0; flush = 0; ex_ready = 0;
    tick();
    rst = 0;
    m = '{default: '0}; m_valid = 0; cyc = 0;
    for (int n = 0; n < 800; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_instr = gen_instr();
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 11) == 0);
      #1;
      cur = ref_decode(id_instr);
      hz = 0;
      // A load accepted by EX at edge k blocks its rd for cycles k .. k+LL-1.
      foreach (loads[i]) begin
        if (cyc - loads[i].k >= 0 && cyc - loads[i].k < LL) begin
          if (cur.u1 && cur.rs1 != 0 && cur.rs1 == loads[i].rd) hz = 1;
          if (cur.u2 && cur.rs2 != 0 && cur.rs2 == loads[i].rd) hz = 1;
        end
      end
      if (m_valid && m.mr && m.rd != 0) begin
        if (cur.u1 && cur.rs1 != 0 && cur.rs1 == m.rd) hz = 1;
        if (cur.u2 && cur.rs2 != 0 && cur.rs2 == m.rd) hz = 1;
      end
      exp_ready = (!m_valid || ex_ready) && !hz && !flush;
      total++;
      if (id_ready !== exp_ready) begin
        bad++; $display("FAIL rnd_id_ready n=%0d instr=%h got=%b exp=%b", n, id_instr, id_ready, exp_ready);
      end
      if (m_valid && ex_ready && m.mr && m.rd != 0) loads.push_back('{m.rd, cyc + 1});
      if (flush) m_valid = 0;
      else if (id_valid && exp_ready) begin m_valid = 1; m = cur; end
      else if (ex_ready) m_valid = 0;
      tick();
      cyc++;
      total++;
      if (ex_valid !== m_valid) begin
        bad++; $display("FAIL rnd_ex_valid n=%0d got=%b exp=%b", n, ex_valid, m_valid);
      end
      if (m_valid) begin
        total++;
        if (got_bundle() !== pack_ref(m)) begin
          bad++; $display("FAIL rnd_bundle n=%0d got=%h exp=%h", n, got_bundle(), pack_ref(m));
        end
      end
      while (loads.size() > 0 && cyc - loads[0].k >= LL) void'(loads.pop_front());
    end
    id_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_load_x0();
    test_stall_store();
    test_flush();
    test_illegal();
    test_midstall_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
